// File: rtl/ram_pkg.sv
// Shared types for the single-port RAM with fill engine.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  typedef enum logic {
    FILL_CONST = 1'b0,
    FILL_RAMP  = 1'b1
  } fill_mode_t;

  localparam int READ_LAT_MAX = 2;

endpackage

// File: rtl/ram_sp_fill_if.sv
// User access and fill-control bus of ram_sp_fill.
interface ram_sp_fill_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              select;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              fill_start;
  logic              fill_mode;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;

  modport master (
    output select, write, address, data_in, fill_start, fill_mode, fill_value,
    input  data_out, data_valid, busy, done
  );

  modport slave (
    input  select, write, address, data_in, fill_start, fill_mode, fill_value,
    output data_out, data_valid, busy, done
  );
endinterface

// File: rtl/ram_sp_fill_core.sv
// Single-port storage array with registered read; the array itself is never reset.
module ram_core
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array write port; caller guarantees i_addr < DEPTH when enabled.
  always_ff @(posedge clk) begin
    if (i_en && i_we) r_mem[i_addr] <= i_wdata;
  end

  // Registered read; holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (rst)                r_rdata <= '0;
    else if (i_en && !i_we) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_sp_fill.sv
// Single-port RAM with a hardware fill sequencer (constant or 2*addr ramp).
module ram_sp_fill
  import ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  ram_sp_fill_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  function automatic logic [DATA_W-1:0] ramp_word(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] dbl;
    dbl = {a, 1'b0};
    return DATA_W'(dbl);
  endfunction

  fill_state_t       r_state, w_next;
  logic [ADDR_W-1:0] r_cnt, w_cnt_next;
  fill_mode_t        r_mode;
  logic [DATA_W-1:0] r_value;
  logic              w_start, w_fill, w_acc, w_rd, w_in_range;
  logic              w_en, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata, w_core_rdata, w_rdata_p0;
  logic              r_vld_p0, r_oor_p0;

  // Next-state and fill counter advance.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_start    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.fill_start) begin
          w_next     = FILL;
          w_cnt_next = '0;
          w_start    = 1'b1;
        end
      end
      FILL: begin
        if (r_cnt == LAST_ADDR) w_next = DONE;
        else                    w_cnt_next = r_cnt + ADDR_W'(1);
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM state and fill counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Fill pattern is captured once when the fill starts.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_mode  <= fill_mode_t'(bus.fill_mode);
      r_value <= bus.fill_value;
    end
  end

  // Access mux: the fill owns the port; a fill_start in IDLE drops the user access.
  // Reset gates the port so an aborted fill never writes its pending word.
  always_comb begin
    w_fill     = (r_state == FILL);
    w_acc      = bus.select && !w_fill && !w_start && !rst;
    w_in_range = ({1'b0, bus.address} < DEPTH_X);
    w_rd       = w_acc && !bus.write;
    w_en       = !rst && (w_fill || (w_acc && w_in_range));
    w_we       = w_fill || bus.write;
    w_addr     = w_fill ? r_cnt : bus.address;
    if (w_fill) w_wdata = (r_mode == FILL_RAMP) ? ramp_word(r_cnt) : r_value;
    else        w_wdata = bus.data_in;
  end

  ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_en),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_core_rdata)
  );

  // Stage p0: read strobe and out-of-range flag alongside the core read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_oor_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_rd;
      if (w_rd) r_oor_p0 <= !w_in_range;
    end
  end

  assign w_rdata_p0 = r_oor_p0 ? '0 : w_core_rdata;

  if (READ_LAT == READ_LAT_MAX) begin : g_lat2
    logic              r_vld_p1;
    logic [DATA_W-1:0] r_dout_p1;

    // Stage p1: extra output register, loaded only by a fresh read.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld_p1  <= 1'b0;
        r_dout_p1 <= '0;
      end else begin
        r_vld_p1 <= r_vld_p0;
        if (r_vld_p0) r_dout_p1 <= w_rdata_p0;
      end
    end

    assign bus.data_out   = r_dout_p1;
    assign bus.data_valid = r_vld_p1;
  end else begin : g_lat1
    assign bus.data_out   = w_rdata_p0;
    assign bus.data_valid = r_vld_p0;
  end

  assign bus.busy = (r_state == FILL);
  assign bus.done = (r_state == DONE);

endmodule

// File: tb/tb_ram_sp_fill.sv
// Scoreboard bench: three instances (1024/lat1, 1024/lat2, 1000/lat1).
module tb_ram_sp_fill;
  import ram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       sel [3], wr [3], fs [3], fm [3];
  logic [9:0] adr [3];
  logic [7:0] din [3], fv [3];
  logic [7:0] dout [3];
  logic       dv [3], bsy [3], dn [3];

  ram_sp_fill_if #(.DATA_W(8), .ADDR_W(10)) bx [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bx[g].select     = sel[g];
    assign bx[g].write      = wr[g];
    assign bx[g].address    = adr[g];
    assign bx[g].data_in    = din[g];
    assign bx[g].fill_start = fs[g];
    assign bx[g].fill_mode  = fm[g];
    assign bx[g].fill_value = fv[g];
    assign dout[g] = bx[g].data_out;
    assign dv[g]   = bx[g].data_valid;
    assign bsy[g]  = bx[g].busy;
    assign dn[g]   = bx[g].done;

    ram_sp_fill #(
      .DATA_W   (8),
      .ADDR_W   (10),
      .DEPTH    ((g == 2) ? 1000 : 1024),
      .READ_LAT ((g == 1) ? 2 : 1)
    ) u_dut (
      .clk (clk),
      .rst (rst[g]),
      .bus (bx[g])
    );
  end

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  int checks;
  int errors;
  int bcnt [3];
  int dcnt [3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic mon_one(input int k);
    logic [7:0] e;
    if (bsy[k] === 1'b1) bcnt[k]++;
    if (dn[k] === 1'b1) dcnt[k]++;
    if (dv[k] === 1'b1) begin
      if (qsize(k) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid dut%0d data=%0d", k, dout[k]);
      end else begin
        case (k)
          0: e = q0.pop_front();
          1: e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("read_dut%0d", k), int'(dout[k]), int'(e));
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) mon_one(k);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int k, input int a, input int e);
    sel[k] = 1'b1; wr[k] = 1'b0; adr[k] = 10'(a);
    push(k, 8'(e));
    cyc();
    sel[k] = 1'b0;
  endtask

  task automatic wrt(input int k, input int a, input int d);
    sel[k] = 1'b1; wr[k] = 1'b1; adr[k] = 10'(a); din[k] = 8'(d);
    cyc();
    sel[k] = 1'b0; wr[k] = 1'b0;
  endtask

  task automatic start_fill(input int k, input int m, input int v);
    fs[k] = 1'b1; fm[k] = m[0]; fv[k] = 8'(v);
    cyc();
    fs[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int d0, input string name);
    int n;
    n = 0;
    while (dcnt[k] == d0 && n < 3000) begin
      cyc();
      n++;
    end
    if (n >= 3000) chk({name, "_timeout"}, n, 0);
    repeat (3) cyc();
  endtask

  task automatic fill_and_check(input int k, input int m, input int v, input string name);
    int b0, d0;
    b0 = bcnt[k]; d0 = dcnt[k];
    start_fill(k, m, v);
    wait_done(k, d0, name);
    chk({name, "_busy_cycles"}, bcnt[k] - b0, (k == 2) ? 1000 : 1024);
    chk({name, "_done_pulses"}, dcnt[k] - d0, 1);
  endtask

  int addrs [20] = '{0, 1, 2, 3, 17, 64, 127, 128, 255, 256,
                     300, 511, 512, 600, 777, 800, 999, 1000, 1022, 1023};

  initial begin
    int b0, d0;
    checks = 0; errors = 0;
    for (int k = 0; k < 3; k++) begin
      bcnt[k] = 0; dcnt[k] = 0;
      rst[k] = 1'b1; sel[k] = 1'b0; wr[k] = 1'b0; fs[k] = 1'b0; fm[k] = 1'b0;
      adr[k] = '0; din[k] = '0; fv[k] = '0;
    end
    fork
      monitor();
    join_none
    repeat (3) cyc();
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_data_out%0d", k), int'(dout[k]), 0);
      chk($sformatf("reset_valid%0d", k), int'(dv[k]), 0);
      chk($sformatf("reset_busy%0d", k), int'(bsy[k]), 0);
      chk($sformatf("reset_done%0d", k), int'(dn[k]), 0);
    end
    cyc();

    // Constant fill, then scattered reads.
    fill_and_check(0, 0, 'hA5, "const_fill");
    foreach (addrs[i]) rd(0, addrs[i], 'hA5);
    repeat (3) cyc();

    // Ramp fill with a write and a read attempted while busy.
    b0 = bcnt[0]; d0 = dcnt[0];
    start_fill(0, 1, 0);
    repeat (5) cyc();
    sel[0] = 1'b1; wr[0] = 1'b1; adr[0] = 10'd5; din[0] = 8'h77;
    cyc();
    wr[0] = 1'b0; adr[0] = 10'd200;
    cyc();
    sel[0] = 1'b0;
    wait_done(0, d0, "ramp_fill");
    chk("ramp_busy_cycles", bcnt[0] - b0, 1024);
    chk("ramp_done_pulses", dcnt[0] - d0, 1);
    rd(0, 0, 0); rd(0, 1, 2); rd(0, 127, 254); rd(0, 128, 0);
    rd(0, 1023, 254); rd(0, 5, 10); rd(0, 200, 144);
    repeat (3) cyc();
    @(negedge clk);
    chk("hold_data_out", int'(dout[0]), 144);
    chk("idle_valid_low", int'(dv[0]), 0);
    cyc();

    // fill_start together with a user write, plus a second start mid-fill.
    b0 = bcnt[0]; d0 = dcnt[0];
    sel[0] = 1'b1; wr[0] = 1'b1; adr[0] = 10'd3; din[0] = 8'hFF;
    fs[0] = 1'b1; fm[0] = 1'b0; fv[0] = 8'h00;
    cyc();
    sel[0] = 1'b0; wr[0] = 1'b0; fs[0] = 1'b0;
    repeat (300) cyc();
    fs[0] = 1'b1; fm[0] = 1'b1; fv[0] = 8'h55;
    cyc();
    fs[0] = 1'b0;
    wait_done(0, d0, "conflict_fill");
    chk("conflict_busy_cycles", bcnt[0] - b0, 1024);
    chk("conflict_done_pulses", dcnt[0] - d0, 1);
    rd(0, 3, 0); rd(0, 500, 0); rd(0, 1023, 0);
    repeat (3) cyc();

    // Reset while the ramp fill is writing word 100.
    fill_and_check(0, 0, 'h11, "prefill");
    d0 = dcnt[0];
    start_fill(0, 1, 0);
    repeat (100) cyc();
    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(bsy[0]), 0);
    repeat (30) cyc();
    chk("abort_no_done", dcnt[0] - d0, 0);
    rd(0, 99, 198); rd(0, 100, 'h11); rd(0, 101, 'h11);
    rd(0, 1023, 'h11); rd(0, 0, 0); rd(0, 50, 100);
    repeat (3) cyc();

    // Two-cycle read latency, back-to-back reads.
    wrt(1, 7, 'h3C);
    sel[1] = 1'b1; wr[1] = 1'b0; adr[1] = 10'd7;
    push(1, 8'h3C);
    cyc();
    push(1, 8'h3C);
    @(negedge clk);
    chk("lat2_not_yet", int'(dv[1]), 0);
    cyc();
    sel[1] = 1'b0;
    @(negedge clk);
    chk("lat2_valid_t2", int'(dv[1]), 1);
    chk("lat2_data_t2", int'(dout[1]), 'h3C);
    cyc();
    @(negedge clk);
    chk("lat2_valid_t3", int'(dv[1]), 1);
    chk("lat2_data_t3", int'(dout[1]), 'h3C);
    cyc();
    @(negedge clk);
    chk("lat2_valid_off", int'(dv[1]), 0);
    cyc();

    // Read in flight when a fill starts returns pre-fill data.
    b0 = bcnt[1]; d0 = dcnt[1];
    sel[1] = 1'b1; wr[1] = 1'b0; adr[1] = 10'd7;
    push(1, 8'h3C);
    cyc();
    sel[1] = 1'b0;
    start_fill(1, 0, 'h99);
    wait_done(1, d0, "lat2_fill");
    chk("lat2_fill_busy_cycles", bcnt[1] - b0, 1024);
    rd(1, 7, 'h99);
    repeat (4) cyc();

    // Depth 1000: short fill and out-of-range accesses.
    fill_and_check(2, 0, 'h42, "d1000_fill");
    wrt(2, 1010, 'hFF);
    rd(2, 1010, 0); rd(2, 999, 'h42); rd(2, 0, 'h42); rd(2, 1023, 0);
    repeat (4) cyc();

    for (int k = 0; k < 3; k++) chk($sformatf("queue_empty%0d", k), qsize(k), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
